// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared codops, FSM states and flag indices for the ALU sequencer/arbiter
package alu_pkg;

  localparam int ALU_W    = 16;
  localparam int ALU_OP_W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_INC  = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SUBI = 4'd10;
  localparam logic [3:0] OP_IDLE = 4'd15;

  localparam logic [3:0] OP_MAX_LEGAL = 4'd10;

  localparam int FLAG_NEG  = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; last pointer moves only on an accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_idx_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_q;
    end else if (req_i[1]) begin
      gnt_idx_o = 1'b1;
    end
    gnt_o = 2'b00;
    if (req_i != 2'b00) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
    last_d = accept_i ? gnt_idx_o : last_q;
  end

  // Reset to 1 so port 0 wins the first contended grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port sequencer in front of the shared ALU, one op in flight.
// Optional sticky overflow per port when ALU_OVF_STICKY_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int               W       = ALU_W,
  parameter int               OP_W    = ALU_OP_W,
  parameter logic [OP_W-1:0]  IDLE_OP = OP_IDLE,
  parameter logic [OP_W-1:0]  MAX_OP  = OP_MAX_LEGAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_codop,
  input  logic [2*W-1:0]    req_a,
  input  logic [2*W-1:0]    req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [2:0]        rsp_flags,
  output logic              rsp_illegal,
  output logic [1:0]        ovf_sticky,
  input  logic [1:0]        ovf_clr,
  output logic [OP_W-1:0]   alu_codop,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_neg,
  input  logic              alu_zero,
  input  logic              alu_overflow
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] codop_q, codop_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            port_q, port_d;
  logic [W-1:0]    data_q, data_d;
  logic [2:0]      flags_q, flags_d;
  logic            illegal_q, illegal_d;
  logic [1:0]      arb_req, arb_gnt;
  logic            arb_idx, accept, rsp_hs;

  // Requests are only visible to the arbiter while idle, so req_ready is zero elsewhere.
  assign arb_req   = req_valid & {2{state_q == ST_IDLE}};
  assign req_ready = arb_gnt;
  assign accept    = |arb_gnt;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .accept_i  (accept),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    codop_d   = codop_q;
    a_d       = a_q;
    b_d       = b_q;
    port_d    = port_q;
    data_d    = data_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    alu_codop = IDLE_OP;
    alu_a     = '0;
    alu_b     = '0;
    rsp_valid = 2'b00;
    rsp_hs    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          codop_d = arb_idx ? req_codop[2*OP_W-1:OP_W] : req_codop[OP_W-1:0];
          a_d     = arb_idx ? req_a[2*W-1:W] : req_a[W-1:0];
          b_d     = arb_idx ? req_b[2*W-1:W] : req_b[W-1:0];
          port_d  = arb_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_codop = codop_q;
        alu_a     = a_q;
        alu_b     = b_q;
        state_d   = ST_CAPT;
      end
      ST_CAPT: begin
        // Inputs stay held so the combinational overflow still belongs to this op.
        alu_codop          = codop_q;
        alu_a              = a_q;
        alu_b              = b_q;
        data_d             = alu_out;
        flags_d[FLAG_OVF]  = alu_overflow;
        flags_d[FLAG_ZERO] = alu_zero;
        flags_d[FLAG_NEG]  = alu_neg;
        illegal_d          = (codop_q > MAX_OP);
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[port_q] = 1'b1;
        if (rsp_ready[port_q]) begin
          rsp_hs  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      codop_q   <= IDLE_OP;
      a_q       <= '0;
      b_q       <= '0;
      port_q    <= 1'b0;
      data_q    <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      codop_q   <= codop_d;
      a_q       <= a_d;
      b_q       <= b_d;
      port_q    <= port_d;
      data_q    <= data_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign rsp_data    = data_q;
  assign rsp_flags   = flags_q;
  assign rsp_illegal = illegal_q;

`ifdef ALU_OVF_STICKY_EN
  logic [1:0] sticky_q, sticky_d, sticky_set;

  // A set on the handshake edge beats a same-edge clear.
  always_comb begin
    sticky_set = 2'b00;
    if (rsp_hs && flags_q[FLAG_OVF]) begin
      sticky_set[port_q] = 1'b1;
    end
    sticky_d = (sticky_q & ~ovf_clr) | sticky_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf_clr | rsp_hs;
  assign ovf_sticky = 2'b00;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer and two-port arbiter in front of the shared 16-bit ALU.
- Accepts operation requests from two requesters (port 0: execute stage, port 1: address/branch unit).
- Grants one at a time round-robin, drives ALU codop/a/b, holds them across the ALU's one-cycle registered latency, captures result plus neg/zero/overflow, returns them to the granted requester over a valid/ready response.
- Sits between the control path and the ALU instance.

Parameters:
- W, 16, operand/result width
- OP_W, 4, codop width
- IDLE_OP, 4'd15, codop driven while idle (ALU default case, result 0)
- MAX_OP, 4'd10, highest legal codop

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accept
- req_codop  in  2*OP_W  port i at [i*OP_W +: OP_W]
- req_a  in  2*W  operand a, port i at [i*W +: W]
- req_b  in  2*W  operand b, same packing
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response accept
- rsp_data  out  W  result (shared bus, valid for the port whose rsp_valid is high)
- rsp_flags  out  3  {overflow, zero, neg}
- rsp_illegal  out  1  codop > MAX_OP
- ovf_sticky  out  2  per-port sticky overflow (optional feature)
- ovf_clr  in  2  per-port sticky clear
- alu_codop  out  OP_W  to ALU
- alu_a  out  W  to ALU
- alu_b  out  W  to ALU
- alu_out  in  W  from ALU (registered there)
- alu_neg, alu_zero, alu_overflow  in  1 each  from ALU

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_flags=0; rsp_illegal=0; ovf_sticky=0.
  - RR pointer last=1, so port 0 wins first.
  - alu_codop=IDLE_OP, alu_a=alu_b=0.
  - In-flight op discarded, no response.
- FSM IDLE -> ISSUE -> CAPT -> RESP -> IDLE; one op in flight.
- IDLE:
  - grant g = requester with valid; if both valid, g = the port not equal to last.
  - req_ready[g]=1 combinationally, other port 0; req_ready=0 in all other states.
  - On valid&ready: latch codop/a/b into op regs, last<=g, go ISSUE.
- ISSUE: alu_codop/a/b = op regs; ALU registers out at end of cycle.
- CAPT:
  - ALU inputs still held; alu_overflow is combinational from inputs and must match the op.
  - At end of cycle: rsp_data<=alu_out, rsp_flags<={alu_overflow,alu_zero,alu_neg}, rsp_illegal<=(codop>MAX_OP).
- RESP:
  - rsp_valid[g]=1, data/flags stable until rsp_ready[g]; then IDLE.
  - ALU inputs return to IDLE_OP/0.
- Timing:
  - Accept in cycle N -> rsp_valid in cycle N+3.
  - Earliest next accept is cycle N+4 (if rsp_ready in N+3); peak 1 op/4 cycles.
- Illegal codop (11..15): still accepted and sequenced with the same latency. ALU yields 0, so data=0, flags={0,1,0}, rsp_illegal=1.
- Requester may drop req_valid before acceptance; no state change.
- rsp_ready on a non-granted port is ignored.
- No wrap concerns; arithmetic lives in the ALU; block only routes.

Optional Feature:
- ALU_OVF_STICKY_EN defined:
  - ovf_sticky[g] set on the RESP handshake cycle when rsp_flags[2]=1.
  - ovf_clr[i] clears bit i next edge; set wins over clear on the same edge.
- Undefined: ovf_sticky tied 0, ovf_clr ignored.

Decomposition:
- Shared package alu_pkg holds:
  - codop constants (ADD=0 .. SUBI=10, IDLE_OP)
  - MAX_OP
  - FSM state enum (IDLE, ISSUE, CAPT, RESP)
  - flag bit indices (NEG=0, ZERO=1, OVF=2)
- One sub-module: rr_arb2, a 2-way round-robin grant with last-pointer update on accept.
- ALU stays instantiated outside.

Test Plan:
- Port0 ADD a=3,b=4 alone -> accept cycle N; alu_codop=0 in N+1..N+2; rsp_valid[0] at N+3, data=7, flags=000, illegal=0.
- Both valid from reset: port0 SUBI a=5,b=9, port1 XOR a=16'hFF00,b=16'h0FF0 -> port0 first: data=16'hFFFC, flags={1,0,1}; then port1: data=16'hF0F0, flags=001.
- Port0 held valid continuously plus port1 valid -> grants alternate 0,1,0,1; neither starved.
- rsp_ready[0] held low 5 cycles -> rsp_valid/data stable, req_ready=0 throughout; then IDLE.
- Codop 13 -> data=0, flags=010, rsp_illegal=1, latency 3.
- rst_n=0 in CAPT -> next cycle state IDLE, no rsp_valid, alu_codop=15; with ALU_OVF_STICKY_EN, ADDI 16'hFFFF+2 sets ovf_sticky[g], ovf_clr clears it.
